// File: rtl/preset_seq_pkg.sv
// Shared types for the preset register command sequencer.
// Optional shadow register build switch: PRESET_SEQ_SHADOW_EN.
package preset_seq_pkg;

  localparam int GAP_CNT_W = 4;
  localparam int CMD_W     = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_PRESET = 2'd2,
    OP_CLEAR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    op_t              op;
    logic [CMD_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/preset_seq_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so
// full/empty fall out of a plain compare.
module preset_seq_fifo
  import preset_seq_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cmd_t
) (
  input  logic   clk,
  input  logic   sync_rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  entry_t      mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/preset_reg_cmd_sequencer.sv
// Issues queued register commands as single-cycle strobes.
// Define PRESET_SEQ_SHADOW_EN to build the shadow copy of the register.
module preset_reg_cmd_sequencer
  import preset_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             reg_enable,
  output logic             reg_sync_preset,
  output logic             reg_sync_rst,
  output logic [WIDTH-1:0] reg_data,
  output logic             cmd_issued,
  output logic             busy,
  output logic [WIDTH-1:0] shadow_q
);

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [GAP_CNT_W-1:0] GAP_INIT =
    GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t state;
  state_t state_nxt;

  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt_nxt;

  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  entry_t wr_cmd;
  entry_t head;

  logic load_hit;
  logic preset_hit;
  logic clear_hit;

  assign in_ready = !full && !sync_rst;
  assign push     = in_valid && in_ready;
  assign busy     = !empty || (state != IDLE);

  assign wr_cmd.op   = op_t'(in_op);
  assign wr_cmd.data = in_data;

  preset_seq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .push     (push),
    .wdata    (wr_cmd),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      IDLE: begin
        if (!empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_INIT;
        end else begin
          state_nxt = empty ? IDLE : ISSUE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = empty ? IDLE : ISSUE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The head is popped on the edge that enters ISSUE, so the
  // registered strobes are visible for exactly the ISSUE cycle.
  assign pop = (state_nxt == ISSUE) && !sync_rst;

  always_comb begin
    load_hit   = 1'b0;
    preset_hit = 1'b0;
    clear_hit  = 1'b0;
    if (pop) begin
      unique case (head.op)
        OP_LOAD:   load_hit   = 1'b1;
        OP_PRESET: preset_hit = 1'b1;
        OP_CLEAR:  clear_hit  = 1'b1;
        OP_NOP:    ;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      reg_enable      <= 1'b0;
      reg_sync_preset <= 1'b0;
      reg_sync_rst    <= 1'b1;
      reg_data        <= '0;
      cmd_issued      <= 1'b0;
    end else begin
      reg_enable      <= load_hit;
      reg_sync_preset <= preset_hit;
      reg_sync_rst    <= clear_hit;
      cmd_issued      <= pop;
      if (load_hit) reg_data <= head.data;
    end
  end

`ifdef PRESET_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow;

  // Gated by cmd_issued so the reset-time clear strobe is not replayed.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      shadow <= '0;
    end else if (cmd_issued) begin
      if (reg_enable)           shadow <= reg_data;
      else if (reg_sync_preset) shadow <= '1;
      else if (reg_sync_rst)    shadow <= '0;
    end
  end

  assign shadow_q = shadow;
`else
  assign shadow_q = '0;
`endif

endmodule

// File: tb/tb_preset_reg_cmd_sequencer.sv
// Bench: directed vector table, full/reset sequences, and random
// traffic on GAP_CYCLES=0 and GAP_CYCLES=3 instances vs a queue model.
module tb_preset_reg_cmd_sequencer;
  import preset_seq_pkg::*;

`ifdef PRESET_SEQ_SHADOW_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  localparam int DEPTH = 4;
  localparam int GAP0  = 0;
  localparam int GAP3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      v;
  logic [1:0][1:0] op;
  logic [1:0][7:0] d;
  logic [1:0]      rdy, en, pre, srst, iss, bsy;
  logic [1:0][7:0] rdata, sh;

  preset_reg_cmd_sequencer #(
    .WIDTH(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP0)
  ) dut0 (
    .clk(clk), .sync_rst(rst),
    .in_valid(v[0]), .in_ready(rdy[0]),
    .in_op(op[0]), .in_data(d[0]),
    .reg_enable(en[0]), .reg_sync_preset(pre[0]),
    .reg_sync_rst(srst[0]), .reg_data(rdata[0]),
    .cmd_issued(iss[0]), .busy(bsy[0]),
    .shadow_q(sh[0])
  );

  preset_reg_cmd_sequencer #(
    .WIDTH(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP3)
  ) dut3 (
    .clk(clk), .sync_rst(rst),
    .in_valid(v[1]), .in_ready(rdy[1]),
    .in_op(op[1]), .in_data(d[1]),
    .reg_enable(en[1]), .reg_sync_preset(pre[1]),
    .reg_sync_rst(srst[1]), .reg_data(rdata[1]),
    .cmd_issued(iss[1]), .busy(bsy[1]),
    .shadow_q(sh[1])
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: a queue per instance plus the cycle of the last issue.
  logic [9:0] mbuf [2][DEPTH];
  int         mhead [2];
  int         mcnt  [2];
  int         mlast [2];
  bit         mhave [2];
  bit         mpend [2];
  logic [9:0] mpcmd [2];

  logic [1:0]      e_en, e_pre, e_rst, e_iss, e_bsy;
  logic [1:0][7:0] e_data, e_sh;

  task automatic model_edge(input int k);
    int         g;
    bit         fire;
    bit         acc;
    logic [9:0] c;
    g = (k == 0) ? GAP0 : GAP3;
    if (rst) begin
      mcnt[k]  = 0;
      mhead[k] = 0;
      mhave[k] = 0;
      mpend[k] = 0;
      e_en[k]  = 1'b0;
      e_pre[k] = 1'b0;
      e_rst[k] = 1'b1;
      e_iss[k] = 1'b0;
      e_bsy[k] = 1'b0;
      e_data[k] = 8'h00;
      e_sh[k]   = 8'h00;
      return;
    end
    if (mpend[k]) begin
      case (mpcmd[k][9:8])
        2'd1:    e_sh[k] = mpcmd[k][7:0];
        2'd2:    e_sh[k] = 8'hFF;
        2'd3:    e_sh[k] = 8'h00;
        default: ;
      endcase
    end
    acc  = v[k] && (mcnt[k] < DEPTH);
    fire = (mcnt[k] > 0) && (!mhave[k] || (cyc - mlast[k] > g));
    e_en[k]  = 1'b0;
    e_pre[k] = 1'b0;
    e_rst[k] = 1'b0;
    e_iss[k] = fire;
    mpend[k] = fire;
    if (fire) begin
      c = mbuf[k][mhead[k]];
      mhead[k] = (mhead[k] + 1) % DEPTH;
      mcnt[k]--;
      mpcmd[k] = c;
      mhave[k] = 1;
      mlast[k] = cyc;
      case (c[9:8])
        2'd1: begin
          e_en[k]   = 1'b1;
          e_data[k] = c[7:0];
        end
        2'd2:    e_pre[k] = 1'b1;
        2'd3:    e_rst[k] = 1'b1;
        default: ;
      endcase
    end
    if (acc) begin
      mbuf[k][(mhead[k] + mcnt[k]) % DEPTH] = {op[k], d[k]};
      mcnt[k]++;
    end
    e_bsy[k] = (mcnt[k] > 0) || (mhave[k] && (cyc - mlast[k] <= g));
  endtask

  task automatic step();
    logic [7:0] esh;
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      esh = SH_EN ? e_sh[k] : 8'h00;
      chk($sformatf("m%0d_in_ready", k), 32'(rdy[k]),
          32'((mcnt[k] < DEPTH) && !rst));
      chk($sformatf("m%0d_enable", k), 32'(en[k]), 32'(e_en[k]));
      chk($sformatf("m%0d_preset", k), 32'(pre[k]), 32'(e_pre[k]));
      chk($sformatf("m%0d_sync_rst", k), 32'(srst[k]), 32'(e_rst[k]));
      chk($sformatf("m%0d_data", k), 32'(rdata[k]), 32'(e_data[k]));
      chk($sformatf("m%0d_issued", k), 32'(iss[k]), 32'(e_iss[k]));
      chk($sformatf("m%0d_busy", k), 32'(bsy[k]), 32'(e_bsy[k]));
      chk($sformatf("m%0d_shadow", k), 32'(sh[k]), 32'(esh));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic       en;
    logic       pre;
    logic       srst;
    logic       iss;
    logic       busy;
    logic       rdy;
    logic [7:0] data;
    logic [7:0] shv;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic vv, input logic [1:0] o,
    input logic [7:0] dd, input logic e, input logic p,
    input logic s, input logic i, input logic b,
    input logic y, input logic [7:0] q, input logic [7:0] w);
    vec_t t;
    t.rst = r;  t.v = vv;   t.op = o;   t.d = dd;
    t.en = e;   t.pre = p;  t.srst = s; t.iss = i;
    t.busy = b; t.rdy = y;  t.data = q; t.shv = w;
    return t;
  endfunction

  vec_t tbl [10];
  int   nacc;
  int   niss;
  int   last3;
  logic [7:0] nxt3;

  task automatic watch3();
    if (iss[1]) begin
      if (last3 >= 0) chk("issue_spacing", cyc - last3, 4);
      chk("issue_order", 32'(rdata[1]), 32'(nxt3));
      last3 = cyc;
      nxt3  = nxt3 + 8'h01;
    end
  endtask

  initial begin
    rst = 1'b1;
    v   = '0;
    op  = '0;
    d   = '0;

    tbl[0] = mk(1'b1, 1'b0, OP_NOP, 8'h00,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tbl[1] = mk(1'b0, 1'b0, OP_NOP, 8'h00,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    tbl[2] = mk(1'b0, 1'b1, OP_LOAD, 8'hA5,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    tbl[3] = mk(1'b0, 1'b0, OP_NOP, 8'h00,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00);
    tbl[4] = mk(1'b0, 1'b0, OP_NOP, 8'h00,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5);
    tbl[5] = mk(1'b0, 1'b1, OP_PRESET, 8'h3C,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5);
    tbl[6] = mk(1'b0, 1'b1, OP_CLEAR, 8'h5A,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5);
    tbl[7] = mk(1'b0, 1'b1, OP_NOP, 8'h77,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hFF);
    tbl[8] = mk(1'b0, 1'b0, OP_NOP, 8'h00,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00);
    tbl[9] = mk(1'b0, 1'b0, OP_NOP, 8'h00,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00);

    for (int i = 0; i < 10; i++) begin
      rst   = tbl[i].rst;
      v[0]  = tbl[i].v;
      op[0] = tbl[i].op;
      d[0]  = tbl[i].d;
      v[1]  = 1'b0;
      step();
      chk($sformatf("t%0d_enable", i), 32'(en[0]), 32'(tbl[i].en));
      chk($sformatf("t%0d_preset", i), 32'(pre[0]), 32'(tbl[i].pre));
      chk($sformatf("t%0d_sync_rst", i), 32'(srst[0]), 32'(tbl[i].srst));
      chk($sformatf("t%0d_issued", i), 32'(iss[0]), 32'(tbl[i].iss));
      chk($sformatf("t%0d_busy", i), 32'(bsy[0]), 32'(tbl[i].busy));
      chk($sformatf("t%0d_in_ready", i), 32'(rdy[0]), 32'(tbl[i].rdy));
      chk($sformatf("t%0d_data", i), 32'(rdata[0]), 32'(tbl[i].data));
      chk($sformatf("t%0d_shadow", i), 32'(sh[0]),
          32'(SH_EN ? tbl[i].shv : 8'h00));
    end

    // Hold valid into the gapped instance until it back-pressures.
    v[0]  = 1'b0;
    nacc  = 0;
    last3 = -1;
    nxt3  = 8'h10;
    for (int i = 0; i < 10 && rdy[1]; i++) begin
      v[1]  = 1'b1;
      op[1] = OP_LOAD;
      d[1]  = 8'h10 + 8'(i);
      step();
      watch3();
      nacc++;
    end
    chk("accepts_until_full", nacc, 5);
    v[1] = 1'b0;
    step();
    watch3();
    chk("ready_after_pop", 32'(rdy[1]), 1);
    step();
    watch3();
    chk("busy_in_gap", 32'(bsy[1]), 1);

    rst = 1'b1;
    step();
    chk("rst_busy", 32'(bsy[1]), 0);
    chk("rst_issued", 32'(iss[1]), 0);
    chk("rst_shadow", 32'(sh[1]), 0);
    chk("rst_clear_strobe", 32'(srst[1]), 1);
    rst  = 1'b0;
    niss = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      niss += 32'(iss[1]);
    end
    chk("no_issue_after_rst", niss, 0);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 2; k++) begin
        v[k]  = ($urandom_range(0, 2) != 0);
        op[k] = 2'($urandom_range(0, 3));
        d[k]  = 8'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
